// File: rtl/stepper_move_sequencer.sv
// -----------------------------------------------------------------------------
// stepper_move_sequencer
//
// Runs one relative stepper move at a time. It accepts a signed step count and
// a step mode over a valid/ready handshake. It then advances the 4-bit coil
// phase pattern one step at a time, waiting a programmable number of cycles
// after each step. The absolute position is tracked in half-step units.
//
// Ports
//   clk         system clock, all state on the rising edge
//   reset_n     asynchronous active-low reset
//   cmd_valid   command present
//   cmd_ready   high only while idle; accept = cmd_valid & cmd_ready at an edge
//   cmd_steps   signed step count, positive moves forward
//   cmd_half    1 = half-step (position +/-1), 0 = full-step (position +/-2)
//   cmd_delay   wait cycles after each step, 0 behaves as 1
//   abort       end the move at the next step boundary
//   coil        coil drive pattern
//   position    absolute position in half-steps, wraps modulo 2^POS_W
//   busy        high whenever not idle
//   step_pulse  one-cycle pulse, high in the STEP state
//   done        one-cycle pulse at the end of every accepted command
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a command, cmd_ready high
// STEP  | one cycle: advance phase/position, load the delay counter
// WAIT  | inter-step delay, lasts exactly reload cycles
// DONE  | one-cycle done pulse, then back to IDLE
// -----------------------------------------------------------------------------
module stepper_move_sequencer #(
  parameter int STEP_W  = 8,
  parameter int POS_W   = 8,
  parameter int DELAY_W = 20
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [STEP_W-1:0]  cmd_steps,
  input  logic               cmd_half,
  input  logic [DELAY_W-1:0] cmd_delay,
  input  logic               abort,
  output logic [3:0]         coil,
  output logic [POS_W-1:0]   position,
  output logic               busy,
  output logic               step_pulse,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         phase_q, phase_d;
  logic [POS_W-1:0]   position_q, position_d;
  logic [STEP_W-1:0]  remaining_q, remaining_d;
  logic [DELAY_W-1:0] delay_q, delay_d;
  logic [DELAY_W-1:0] reload_q, reload_d;
  logic               dir_q, dir_d;
  logic               half_q, half_d;

  logic [3:0]         coil_q;
  logic               cmd_ready_q;
  logic               busy_q;
  logic               step_pulse_q;
  logic               done_q;

  logic [2:0]         step_inc;

  // Single-coil patterns on even indices, two-coil patterns on odd indices.
  // A full-step move (+/-2) therefore keeps whichever parity it starts on.
  function automatic logic [3:0] phase_coil(input logic [2:0] idx);
    logic [3:0] pat;
    case (idx)
      3'd0:    pat = 4'b0001;
      3'd1:    pat = 4'b0011;
      3'd2:    pat = 4'b0010;
      3'd3:    pat = 4'b0110;
      3'd4:    pat = 4'b0100;
      3'd5:    pat = 4'b1100;
      3'd6:    pat = 4'b1000;
      default: pat = 4'b1001;
    endcase
    return pat;
  endfunction

  assign step_inc = half_q ? 3'd1 : 3'd2;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    position_d  = position_q;
    remaining_d = remaining_q;
    delay_d     = delay_q;
    reload_d    = reload_q;
    dir_d       = dir_q;
    half_d      = half_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          // Magnitude is taken as unsigned so the most negative count
          // becomes 2^(STEP_W-1) instead of overflowing.
          remaining_d = cmd_steps[STEP_W-1] ? (STEP_W'(0) - cmd_steps) : cmd_steps;
          dir_d       = cmd_steps[STEP_W-1];
          half_d      = cmd_half;
          reload_d    = (cmd_delay == '0) ? DELAY_W'(1) : cmd_delay;
          state_d     = (cmd_steps == '0) ? S_DONE : S_STEP;
        end
      end

      S_STEP: begin
        phase_d     = dir_q ? (phase_q - step_inc) : (phase_q + step_inc);
        position_d  = dir_q ? (position_q - POS_W'(step_inc))
                            : (position_q + POS_W'(step_inc));
        remaining_d = remaining_q - STEP_W'(1);
        delay_d     = reload_q;
        // An abort seen here lets the current step land but skips its wait.
        state_d     = abort ? S_DONE : S_WAIT;
      end

      S_WAIT: begin
        delay_d = delay_q - DELAY_W'(1);
        if (abort) begin
          state_d = S_DONE;
        end else if (delay_q == DELAY_W'(1)) begin
          state_d = (remaining_q == '0) ? S_DONE : S_STEP;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state values so they line up with
  // the state they describe without any combinational path to the ports.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      phase_q      <= 3'd0;
      position_q   <= '0;
      remaining_q  <= '0;
      delay_q      <= '0;
      reload_q     <= '0;
      dir_q        <= 1'b0;
      half_q       <= 1'b0;
      coil_q       <= 4'b0001;
      cmd_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      step_pulse_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      position_q   <= position_d;
      remaining_q  <= remaining_d;
      delay_q      <= delay_d;
      reload_q     <= reload_d;
      dir_q        <= dir_d;
      half_q       <= half_d;
      coil_q       <= phase_coil(phase_d);
      cmd_ready_q  <= (state_d == S_IDLE);
      busy_q       <= (state_d != S_IDLE);
      step_pulse_q <= (state_d == S_STEP);
      done_q       <= (state_d == S_DONE);
    end
  end

  assign coil       = coil_q;
  assign position   = position_q;
  assign cmd_ready  = cmd_ready_q;
  assign busy       = busy_q;
  assign step_pulse = step_pulse_q;
  assign done       = done_q;

endmodule

// File: tb/tb_stepper_move_sequencer.sv
module tb_stepper_move_sequencer;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_steps;
  logic        cmd_half;
  logic [19:0] cmd_delay;
  logic        abort;
  logic [3:0]  coil;
  logic [7:0]  position;
  logic        busy;
  logic        step_pulse;
  logic        done;

  int checks   = 0;
  int failures = 0;

  logic [2:0] m_phase;
  logic [7:0] m_pos;

  stepper_move_sequencer #(.STEP_W(8), .POS_W(8), .DELAY_W(20)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_steps  (cmd_steps),
    .cmd_half   (cmd_half),
    .cmd_delay  (cmd_delay),
    .abort      (abort),
    .coil       (coil),
    .position   (position),
    .busy       (busy),
    .step_pulse (step_pulse),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              do_reset;
    logic signed [7:0] steps;
    logic              half;
    logic [19:0]       delay;
    int                exp_pulses;
    logic [7:0]        exp_pos;
    logic [3:0]        exp_coil;
    int                exp_gap;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [3:0] tbl(input logic [2:0] i);
    case (i)
      3'd0: return 4'b0001;
      3'd1: return 4'b0011;
      3'd2: return 4'b0010;
      3'd3: return 4'b0110;
      3'd4: return 4'b0100;
      3'd5: return 4'b1100;
      3'd6: return 4'b1000;
      default: return 4'b1001;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    abort     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    m_phase = 3'd0;
    m_pos   = 8'd0;
  endtask

  task automatic issue(input logic signed [7:0] s, input logic h, input logic [19:0] d);
    @(negedge clk);
    cmd_steps = s;
    cmd_half  = h;
    cmd_delay = d;
    cmd_valid = 1'b1;
    chk("ready_before_accept", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_pulses(input int n, input string name);
    int cnt;
    cnt = 0;
    for (int k = 0; k < 2000 && cnt < n; k++) begin
      @(negedge clk);
      if (step_pulse) cnt++;
    end
    if (cnt < n) chk(name, cnt, n);
  endtask

  task automatic run_move(input logic signed [7:0] s, input logic h, input logic [19:0] d,
                          input int exp_pulses, input int exp_gap);
    int   pulses;
    int   last;
    logic got_done;
    logic [2:0] inc;
    inc      = h ? 3'd1 : 3'd2;
    pulses   = 0;
    last     = 0;
    got_done = 1'b0;
    issue(s, h, d);
    for (int k = 1; k <= 1000 && !got_done; k++) begin
      @(negedge clk);
      if (step_pulse) begin
        if (pulses == 0) chk("first_pulse_latency", k, 1);
        else             chk("pulse_gap", k - last, exp_gap);
        chk("coil_at_step", coil, tbl(m_phase));
        chk("pos_at_step", position, m_pos);
        if (s < 0) begin
          m_phase = m_phase - inc;
          m_pos   = m_pos - 8'(inc);
        end else begin
          m_phase = m_phase + inc;
          m_pos   = m_pos + 8'(inc);
        end
        pulses++;
        last = k;
      end
      if (done) begin
        got_done = 1'b1;
        if (exp_pulses == 0) chk("zero_step_done_latency", k, 1);
        else                 chk("done_after_last_step", k - last, exp_gap);
      end
    end
    chk("done_seen", got_done, 1);
    chk("pulse_count", pulses, exp_pulses);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("ready_after_done", cmd_ready, 1);
  endtask

  initial begin
    int   pulses;
    logic got_done;
    int   kd;

    vecs[0] = '{1'b1,  8'sd3,    1'b0, 20'd4, 3,   8'h06, 4'b1000, 5};
    vecs[1] = '{1'b1, -8'sd2,    1'b1, 20'd2, 2,   8'hFE, 4'b1000, 3};
    vecs[2] = '{1'b0,  8'sd0,    1'b0, 20'd7, 0,   8'hFE, 4'b1000, 0};
    vecs[3] = '{1'b0, -8'sd128,  1'b1, 20'd0, 128, 8'h7E, 4'b1000, 2};
    vecs[4] = '{1'b1,  8'sd1,    1'b1, 20'd0, 1,   8'h01, 4'b0011, 2};
    vecs[5] = '{1'b0,  8'sd3,    1'b0, 20'd1, 3,   8'h07, 4'b1001, 2};
    vecs[6] = '{1'b0, -8'sd1,    1'b0, 20'd3, 1,   8'h05, 4'b1100, 4};
    vecs[7] = '{1'b0,  8'sd127,  1'b1, 20'd2, 127, 8'h84, 4'b0100, 3};

    cmd_steps = '0;
    cmd_half  = 1'b0;
    cmd_delay = '0;

    // Reset values
    do_reset();
    chk("rst_coil", coil, 4'b0001);
    chk("rst_position", position, 8'h00);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_step_pulse", step_pulse, 0);

    // Table-driven moves
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].do_reset) do_reset();
      run_move(vecs[i].steps, vecs[i].half, vecs[i].delay, vecs[i].exp_pulses, vecs[i].exp_gap);
      chk($sformatf("vec%0d_position", i), position, vecs[i].exp_pos);
      chk($sformatf("vec%0d_coil", i), coil, vecs[i].exp_coil);
      chk($sformatf("vec%0d_busy", i), busy, 0);
    end

    // Abort during WAIT after the second step
    do_reset();
    issue(8'sd5, 1'b0, 20'd10);
    wait_pulses(2, "abort_wait_pulses_timeout");
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_wait_done", done, 1);
    chk("abort_wait_position", position, 8'h04);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (step_pulse) pulses++;
    end
    chk("abort_wait_no_more_steps", pulses, 0);
    chk("abort_wait_idle", busy, 0);

    // Abort during the third STEP
    do_reset();
    issue(8'sd5, 1'b0, 20'd10);
    wait_pulses(3, "abort_step_pulses_timeout");
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_step_done", done, 1);
    chk("abort_step_position", position, 8'h06);
    chk("abort_step_coil", coil, 4'b1000);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (step_pulse) pulses++;
    end
    chk("abort_step_no_more_steps", pulses, 0);

    // Commands while busy are ignored; one held through done is taken next
    do_reset();
    issue(8'sd3, 1'b0, 20'd4);
    pulses   = 0;
    got_done = 1'b0;
    kd       = 0;
    for (int k = 1; k <= 60 && !got_done; k++) begin
      @(negedge clk);
      if (step_pulse) pulses++;
      if (done) begin
        got_done = 1'b1;
        kd = k;
      end
      chk("busy_not_ready", cmd_ready, 0);
      if (k >= 2 && k <= 8) begin
        cmd_valid = k[0];
        cmd_steps = -8'sd7;
        cmd_half  = 1'b1;
        cmd_delay = 20'd1;
      end else if (k > 8) begin
        cmd_valid = 1'b1;
        cmd_steps = 8'sd1;
        cmd_half  = 1'b1;
        cmd_delay = 20'd1;
      end
    end
    chk("busy_done_seen", got_done, 1);
    chk("busy_done_cycle", kd, 16);
    chk("busy_pulse_count", pulses, 3);
    chk("busy_position", position, 8'h06);
    @(negedge clk);
    chk("after_done_ready", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("after_done_accepted", step_pulse, 1);
    got_done = 1'b0;
    for (int k = 0; k < 20 && !got_done; k++) begin
      @(negedge clk);
      if (done) got_done = 1'b1;
    end
    chk("after_done_move_done", got_done, 1);
    chk("after_done_position", position, 8'h07);
    chk("after_done_coil", coil, 4'b1001);

    // Asynchronous reset in the middle of WAIT
    do_reset();
    issue(8'sd3, 1'b0, 20'd4);
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_coil", coil, 4'b0001);
    chk("async_rst_position", position, 8'h00);
    chk("async_rst_ready", cmd_ready, 1);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_step_pulse", step_pulse, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    pulses   = 0;
    got_done = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (step_pulse) pulses++;
      if (done) got_done = 1'b1;
    end
    chk("post_reset_no_steps", pulses, 0);
    chk("post_reset_no_done", got_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stepper_move_sequencer.md
Name: stepper_move_sequencer

Overview:
Sequences relative stepper-motor moves for the processor's motor port. It accepts a signed step count with a step mode (full or half) over a valid/ready handshake. It then drives the 4-bit coil phase pattern with a programmable inter-step delay and tracks the absolute position in half-step units. The control FSM issues a command and waits for done, instead of looping on the shared delay counter itself.

Parameters:
STEP_W, 8, width of signed step count and of internal remaining-step counter
POS_W, 8, width of position register, in half-step units
DELAY_W, 20, width of inter-step delay field and delay counter

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid and cmd_ready are both high at an edge
cmd_steps  in  STEP_W  signed two's-complement step count; positive moves forward
cmd_half  in  1  1 = half-step (position ±1 per step), 0 = full-step (position ±2 per step)
cmd_delay  in  DELAY_W  wait cycles after each step; 0 is treated as 1
abort  in  1  stop the move at the next step boundary
coil  out  4  coil drive pattern
position  out  POS_W  absolute position, wraps modulo 2^POS_W
busy  out  1  high in any state except IDLE
step_pulse  out  1  high for exactly the one cycle in STEP
done  out  1  one-cycle pulse in DONE

Behaviour:
- Reset values (asynchronous, immediate on reset_n low):
  - state IDLE, phase index 0, coil 4'b0001, position 0
  - remaining count 0, delay counter 0
  - busy 0, step_pulse 0, done 0, cmd_ready 1
  - Reset mid-move abandons the move with no done pulse.
- Phase table, index 0..7: 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001. coil always equals table[phase index].
- States: IDLE, STEP, WAIT, DONE.
- IDLE:
  - On accept, latch remaining = |cmd_steps|. This is an unsigned STEP_W value, so -2^(STEP_W-1) gives 2^(STEP_W-1).
  - Latch dir = sign bit, inc = cmd_half ? 1 : 2, reload = (cmd_delay == 0) ? 1 : cmd_delay.
  - Next state is DONE if cmd_steps == 0, else STEP.
  - abort is ignored in IDLE.
- STEP (one cycle, step_pulse = 1). On the edge leaving STEP:
  - phase index ± inc, modulo 8
  - position ± inc, modulo 2^POS_W
  - remaining decrements by 1
  - delay counter loads reload
  - next state is WAIT
- WAIT:
  - The delay counter decrements each cycle and WAIT lasts exactly reload cycles.
  - On the last WAIT cycle (counter == 1): go to DONE if remaining == 0, else STEP.
  - Consecutive step_pulses are therefore reload+1 cycles apart.
- DONE: done = 1 for one cycle, then IDLE.
- Abort:
  - abort high in any WAIT cycle goes to DONE on the next edge; no further steps, delay truncated.
  - abort high during STEP lets that step complete, and WAIT is skipped (STEP goes straight to DONE).
  - abort does not reset the latched step mode for the next command.
- Position and phase persist across commands. A full-step move from an odd phase index stays on odd indices (two-coil pattern).
- cmd_valid while busy is not accepted; cmd_ready is low and inputs are not sampled.
- Latency:
  - accept edge → STEP in the next cycle
  - accept → first coil change: 2 edges
  - last step → done: reload+1 cycles after that step_pulse
  - zero-step command → done in the cycle after accept

Test Plan:
1. Reset → hold reset_n low for 3 cycles, then release → coil=0001, position=0, cmd_ready=1, busy=0, done=0. Assert reset mid-WAIT → all outputs return to these values asynchronously.
2. From reset, steps=+3, half=0, delay=4 → three step_pulses 5 cycles apart. coil goes 0001→0010→0100→1000, position ends at 6, done pulses once 5 cycles after the third step_pulse.
3. From reset, steps=-2, half=1, delay=2 → coil goes 0001→1001→1000, position goes 0→0xFF→0xFE, step_pulses 3 cycles apart.
4. steps=0 → done high exactly in the cycle after accept, no step_pulse, coil and position unchanged. steps=-128 with delay=0 → 128 step_pulses 2 cycles apart (delay treated as 1).
5. steps=+5, full, delay=10; assert abort for one cycle during WAIT after the 2nd step → done next cycle, position=4, no third step_pulse. Repeat with abort during the 3rd STEP → position=6, done the cycle after that STEP.
6. Pulse cmd_valid with different steps while busy → ignored, original move completes unchanged. A new cmd_valid in the cycle after done is accepted.
